alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter: DEPTH, default 4, number of request-queue entries (power of two, 2..16).
REQ-002 clk_i  input  1  core clock; all state on rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 flush_i  input  1  discard all queued and pending work.
REQ-005 req_valid_i  input  1  upstream request valid.
REQ-006 req_ready_o  output  1  request accepted when req_valid_i && req_ready_o.
REQ-007 fu_data_i  input  fu_data_t  operator, operand_a/b/imm, trans_id of the request.
REQ-008 alu_fu_data_o  output  fu_data_t  operation driven to the combinational ALU.
REQ-009 alu_result_i  input  64  ALU result for alu_fu_data_o, same cycle.
REQ-010 alu_branch_res_i  input  1  ALU branch compare result, same cycle.
REQ-011 wb_valid_o  output  1  writeback slot holds a result.
REQ-012 wb_ready_i  input  1  consumer accepts the writeback this cycle.
REQ-013 wb_trans_id_o  output  TRANS_ID_BITS  trans_id of the written-back operation.
REQ-014 wb_result_o  output  64  captured alu_result_i.
REQ-015 wb_branch_res_o  output  1  captured alu_branch_res_i.

Function
REQ-016 Requests SHALL be stored in a DEPTH-entry FIFO; count range 0..DEPTH, pointers wrap modulo DEPTH.
REQ-017 req_ready_o SHALL equal (count < DEPTH) && !flush_i, with no combinational path from wb_ready_i.
REQ-018 alu_fu_data_o SHALL be the FIFO head entry; when the FIFO is empty, operator = ADD, operands 0.
REQ-019 Writeback slot has two states, EMPTY and FULL; wb_valid_o = (state == FULL).
REQ-020 Issue SHALL occur when the FIFO is non-empty and (slot EMPTY or wb_ready_i): pop head, capture alu_result_i, alu_branch_res_i, head trans_id into slot, state FULL.
REQ-021 EMPTY->FULL on issue; FULL->EMPTY on wb_ready_i without issue; FULL->FULL on wb_ready_i with issue; FULL holds otherwise, outputs stable.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; results SHALL retire in acceptance order.
REQ-023 Latency (bypass disabled): request accepted at edge N, issued at edge N+1, wb_valid_o high after edge N+1; throughput 1 per cycle when wb_ready_i held high.
REQ-024 When full (count == DEPTH), a simultaneous pop SHALL NOT allow an accept that cycle.
REQ-025 flush_i SHALL, at the next edge, empty the FIFO, set slot EMPTY, and discard any request presented that cycle; no issue occurs in a flush cycle.
REQ-026 Wrap-around: after 2*DEPTH+1 back-to-back pushes/pops, order and data SHALL be preserved.

Reset
REQ-027 On rst_ni low, asynchronously: count=0, pointers=0, slot EMPTY, wb_valid_o=0, wb_trans_id_o=0, wb_result_o=0, wb_branch_res_o=0.
REQ-028 req_ready_o SHALL read 1 from the first cycle after reset release (0 during reset).
REQ-029 Reset mid-operation SHALL discard all queued and pending work; nothing is written back afterwards.

Configuration
REQ-030 Macro ALU_DISPATCH_BYPASS_EN: when defined, if the FIFO is empty and the slot can accept (EMPTY or wb_ready_i), an accepted request SHALL drive alu_fu_data_o directly and be captured into the slot at the same edge, bypassing the FIFO (latency: wb_valid_o high after edge N).
REQ-031 Without ALU_DISPATCH_BYPASS_EN, all requests pass through the FIFO per REQ-023; ordering rules are identical in both builds.

Verification
REQ-032 Reset, push ADD a=5 b=7 trans_id=2, wb_ready_i=1 -> wb_valid_o 1 cycle later (bypass: same edge), wb_result_o=12, wb_trans_id_o=2.
REQ-033 Hold wb_ready_i=0, push DEPTH+1 XORL ops -> req_ready_o=0 after 4 stored + 1 in slot (DEPTH=4, 5 total accepted); wb outputs stable.
REQ-034 Release wb_ready_i=1 after fill -> results drain one per cycle in trans_id order 0,1,2,3,4.
REQ-035 Push EQ a=b=0xFFFF_FFFF_FFFF_FFFF -> wb_branch_res_o=1, wb_result_o=1; NE same operands -> 0, 0.
REQ-036 Three queued entries, assert flush_i with req_valid_i=1 -> next cycle wb_valid_o=0, count=0, flushed request never written back.
REQ-037 Deassert rst_ni with slot FULL and 2 queued -> wb_valid_o=0 immediately, no later writeback of those trans_ids.

Source files
------------

// File: rtl/alu_dispatch.sv
// ALU dispatch: DEPTH-entry request FIFO feeding a combinational ALU, result held in a one-entry writeback slot.
// Accept->wb_valid_o one edge later (same edge with ALU_DISPATCH_BYPASS_EN); req_ready_o drops only on full FIFO or flush.
package alu_dispatch_pkg;
  localparam int TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {ADD, SUB, XORL, ORL, ANDL, EQ, NE, LTU} fu_op_e;

  typedef struct packed {
    fu_op_e                   operator;
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [63:0]              imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;
endpackage

module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  fu_data_t                 fu_data_i,
  output fu_data_t                 alu_fu_data_o,
  input  logic [63:0]              alu_result_i,
  input  logic                     alu_branch_res_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [63:0]              wb_result_o,
  output logic                     wb_branch_res_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

  fu_data_t                 mem_q [DEPTH];
  fu_data_t                 mem_d [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     rdy_en_q, rdy_en_d;
  slot_e                    slot_q, slot_d;
  logic [TRANS_ID_BITS-1:0] wb_tid_q, wb_tid_d;
  logic [63:0]              wb_res_q, wb_res_d;
  logic                     wb_br_q, wb_br_d;

  logic fifo_empty, slot_free, push, bypass, fifo_push, fifo_pop, issue;

  always_comb begin
    fifo_empty  = (count_q == '0);
    slot_free   = (slot_q == SLOT_EMPTY) || wb_ready_i;
    // Readiness depends only on registered state and flush, never on wb_ready_i.
    req_ready_o = rdy_en_q && (count_q != FULL_CNT) && !flush_i;
    push        = req_valid_i && req_ready_o;
`ifdef ALU_DISPATCH_BYPASS_EN
    bypass      = push && fifo_empty && slot_free;
`else
    bypass      = 1'b0;
`endif
    fifo_pop    = !fifo_empty && slot_free && !flush_i;
    fifo_push   = push && !bypass;
    issue       = fifo_pop || bypass;

    alu_fu_data_o          = '0;
    alu_fu_data_o.operator = ADD;
    if (bypass) begin
      alu_fu_data_o = fu_data_i;
    end else if (!fifo_empty) begin
      alu_fu_data_o = mem_q[rd_ptr_q];
    end

    mem_d = mem_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = fu_data_i;
    end
    wr_ptr_d = wr_ptr_q + PW'(fifo_push);
    rd_ptr_d = rd_ptr_q + PW'(fifo_pop);
    count_d  = count_q + CW'(fifo_push) - CW'(fifo_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    rdy_en_d = 1'b1;

    slot_d   = slot_q;
    wb_tid_d = wb_tid_q;
    wb_res_d = wb_res_q;
    wb_br_d  = wb_br_q;
    if (flush_i) begin
      slot_d = SLOT_EMPTY;
    end else if (issue) begin
      slot_d   = SLOT_FULL;
      wb_tid_d = alu_fu_data_o.trans_id;
      wb_res_d = alu_result_i;
      wb_br_d  = alu_branch_res_i;
    end else if (wb_ready_i) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
      slot_q   <= SLOT_EMPTY;
      wb_tid_q <= '0;
      wb_res_q <= '0;
      wb_br_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_en_q <= rdy_en_d;
      slot_q   <= slot_d;
      wb_tid_q <= wb_tid_d;
      wb_res_q <= wb_res_d;
      wb_br_q  <= wb_br_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign wb_valid_o      = (slot_q == SLOT_FULL);
  assign wb_trans_id_o   = wb_tid_q;
  assign wb_result_o     = wb_res_q;
  assign wb_branch_res_o = wb_br_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized and directed bench for alu_dispatch against a queue-based behavioural model.
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic req_valid = 1'b0;
  logic wb_ready = 1'b0;
  logic req_ready, wb_valid, wb_br, alu_br;
  fu_data_t req_dat, alu_dat;
  logic [63:0] alu_res, wb_res;
  logic [TRANS_ID_BITS-1:0] wb_tid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [64:0] alu_eval(input fu_data_t f);
    logic [63:0] a, b;
    a = f.operand_a;
    b = f.operand_b;
    case (f.operator)
      ADD:     return {1'b0, a + b};
      SUB:     return {1'b0, a - b};
      XORL:    return {1'b0, a ^ b};
      ORL:     return {1'b0, a | b};
      ANDL:    return {1'b0, a & b};
      EQ:      return {a == b, 63'd0, a == b};
      NE:      return {a != b, 63'd0, a != b};
      LTU:     return {a < b, 63'd0, a < b};
      default: return '0;
    endcase
  endfunction

  always_comb {alu_br, alu_res} = alu_eval(alu_dat);

  alu_dispatch #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .fu_data_i(req_dat),
    .alu_fu_data_o(alu_dat), .alu_result_i(alu_res), .alu_branch_res_i(alu_br),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_trans_id_o(wb_tid),
    .wb_result_o(wb_res), .wb_branch_res_o(wb_br)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: queue of accepted requests plus the one visible writeback result.
  fu_data_t m_fifo[$];
  fu_data_t m_head, exp_alu;
  bit m_full = 0;
  bit m_rdy_en = 0;
  logic [TRANS_ID_BITS-1:0] m_tid = '0;
  logic [63:0] m_res = '0;
  logic m_br = 1'b0;
  bit exp_ready, accept, sfree;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_fifo.delete();
      m_full = 0; m_rdy_en = 0; m_tid = '0; m_res = '0; m_br = 1'b0;
    end
    exp_ready = rst_n && m_rdy_en && (m_fifo.size() < DEPTH) && !flush;
    accept    = req_valid && exp_ready;
    sfree     = !m_full || wb_ready;
    exp_alu = '0;
    exp_alu.operator = ADD;
    if (m_fifo.size() > 0) exp_alu = m_fifo[0];
`ifdef ALU_DISPATCH_BYPASS_EN
    else if (accept && sfree) exp_alu = req_dat;
`endif
    check("wb_valid", wb_valid, m_full);
    if (m_full || !rst_n) begin
      check("wb_trans_id", wb_tid, m_tid);
      check("wb_result", wb_res, m_res);
      check("wb_branch_res", wb_br, m_br);
    end
    check("req_ready", req_ready, exp_ready);
    checks++;
    if (alu_dat !== exp_alu) begin
      errors++;
      $display("FAIL alu_fu_data @%0t: got %h expected %h", $time, alu_dat, exp_alu);
    end
    if (rst_n) begin
      if (flush) begin
        m_fifo.delete();
        m_full = 0;
      end else begin
        if (m_fifo.size() > 0 && sfree) begin
          m_head = m_fifo.pop_front();
          {m_br, m_res} = alu_eval(m_head);
          m_tid = m_head.trans_id;
          m_full = 1;
        end
`ifdef ALU_DISPATCH_BYPASS_EN
        else if (accept && sfree) begin
          {m_br, m_res} = alu_eval(req_dat);
          m_tid = req_dat.trans_id;
          m_full = 1;
          accept = 0;
        end
`endif
        else if (wb_ready) m_full = 0;
        if (accept) m_fifo.push_back(req_dat);
      end
      m_rdy_en = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input fu_op_e op, input logic [63:0] a, input logic [63:0] b, input int tid);
    bit ok;
    ok = 0;
    req_dat = '0;
    req_dat.operator = op;
    req_dat.operand_a = a;
    req_dat.operand_b = b;
    req_dat.trans_id = TRANS_ID_BITS'(tid);
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      step();
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_timeout: request tid %0d not accepted within 50 cycles", tid);
    end
  endtask

  task automatic wait_tid(input string name, input int tid, input logic [63:0] res, input logic br);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = wb_valid && (wb_tid == TRANS_ID_BITS'(tid));
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: tid %0d never written back", name, tid);
    end else begin
      check({name, "_result"}, wb_res, res);
      check({name, "_branch"}, wb_br, {63'd0, br});
    end
  endtask

  logic [63:0] xa [DEPTH+1];
  logic [63:0] xb [DEPTH+1];
  logic [63:0] ones;

  initial begin
    ones = '1;
    req_dat = '0;
    repeat (2) @(negedge clk);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_trans_id", wb_tid, 0);
    check("rst_wb_result", wb_res, 0);
    check("rst_wb_branch", wb_br, 0);
    check("rst_req_ready", req_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);
    step();

    // Single ADD, result visible one edge after acceptance.
    wb_ready = 1'b1;
    push(ADD, 64'd5, 64'd7, 2);
`ifndef ALU_DISPATCH_BYPASS_EN
    step();
`endif
    @(negedge clk);
    check("add_wb_valid", wb_valid, 1);
    check("add_wb_result", wb_res, 64'd12);
    check("add_wb_trans_id", wb_tid, 2);
    step();
    repeat (3) step();

    // Fill FIFO and slot with consumer stalled.
    wb_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      xa[i] = {$urandom, $urandom};
      xb[i] = {$urandom, $urandom};
      push(XORL, xa[i], xb[i], i);
    end
    req_dat.trans_id = TRANS_ID_BITS'(5);
    req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_req_ready", req_ready, 0);
      check("full_wb_valid", wb_valid, 1);
      check("full_wb_trans_id", wb_tid, 0);
      check("full_wb_result", wb_res, xa[0] ^ xb[0]);
      step();
    end
    req_valid = 1'b0;

    // Drain one per cycle in acceptance order.
    wb_ready = 1'b1;
    for (int k = 0; k <= DEPTH; k++) begin
      @(negedge clk);
      check("drain_wb_valid", wb_valid, 1);
      check("drain_wb_trans_id", wb_tid, k);
      check("drain_wb_result", wb_res, xa[k] ^ xb[k]);
      step();
    end

    push(EQ, ones, ones, 3);
    wait_tid("eq", 3, 64'd1, 1'b1);
    step();
    push(NE, ones, ones, 4);
    wait_tid("ne", 4, 64'd0, 1'b0);
    step();

    // Flush with queued work and a request presented in the same cycle.
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(ADD, 64'(i), 64'd10, i);
    req_dat.trans_id = TRANS_ID_BITS'(7);
    req_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_wb_valid", wb_valid, 0);
    check("flush_req_ready", req_ready, 1);
    step();
    wb_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("flush_no_wb", wb_valid, 0);
      step();
    end

    // Reset with slot full and two entries queued.
    wb_ready = 1'b0;
    for (int i = 1; i <= 3; i++) push(ORL, 64'(i), 64'h100, i);
    rst_n = 1'b0;
    #1;
    check("rst_wb_valid_immediate", wb_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    wb_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rst_no_wb", wb_valid, 0);
      step();
    end

    // Back-to-back traffic past pointer wrap.
    for (int i = 0; i <= 2 * DEPTH; i++) push(SUB, {$urandom, $urandom}, {$urandom, $urandom}, i % 8);
    repeat (3) step();

    repeat (600) begin
      req_valid = ($urandom_range(0, 9) < 7);
      wb_ready  = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      req_dat.operator  = fu_op_e'(4'($urandom_range(0, 7)));
      req_dat.operand_a = {$urandom, $urandom};
      req_dat.operand_b = ($urandom_range(0, 3) == 0) ? req_dat.operand_a : {$urandom, $urandom};
      req_dat.imm       = {$urandom, $urandom};
      req_dat.trans_id  = TRANS_ID_BITS'($urandom_range(0, 7));
      step();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    req_valid = 1'b0;
    wb_ready = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
